// File: rtl/bist_pkg.sv
// Shared BIST definitions: TPG state encoding and the Galois LFSR step
// used by both the pattern generator and MISR-side models.
package bist_pkg;

    localparam int LFSR_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } tpg_state_t;

    // Right-shifting Galois step on the low w bits; bits above w are forced to 0.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] q,
        input logic [LFSR_MAX_W-1:0] poly,
        input int                    w
    );
        logic [LFSR_MAX_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < LFSR_MAX_W; i++) begin
            if (i < w) mask[i] = 1'b1;
        end
        return ((q & mask) >> 1) ^ ({LFSR_MAX_W{q[0]}} & poly & mask);
    endfunction

endpackage

// File: rtl/bist_delay_line.sv
// LAT-deep single-bit delay line with synchronous active-low reset;
// every stage clears on reset so no stale pulse can leak out afterwards.
module bist_delay_line #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [LAT-1:0] r_sr;

    generate
        if (LAT == 1) begin : g_one
            always_ff @(posedge clk) begin
                if (!rst) r_sr <= '0;
                else      r_sr <= i_d;
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (!rst) r_sr <= '0;
                else      r_sr <= {r_sr[LAT-2:0], i_d};
            end
        end
    endgenerate

    assign o_q = r_sr[LAT-1];

endmodule

// File: rtl/bist_tpg.sv
// LFSR test pattern generator for the BIST datapath with hold stall and a
// latency-matched MISR enable. Optional macro TPG_SEED_GUARD_EN replaces a zero seed.
module bist_tpg
    import bist_pkg::*;
#(
    parameter int n     = 8,
    parameter int CNT_W = 16,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    input  logic [n-1:0]     poly,
    input  logic [n-1:0]     seed,
    input  logic [CNT_W-1:0] num_pat,
    output logic [n-1:0]     pattern,
    output logic             pat_valid,
    output logic             misr_en,
    output logic             busy,
    output logic             done,
`ifdef TPG_SEED_GUARD_EN
    output logic             seed_err,
`endif
    output tpg_state_t       dbg_state
);

    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

    tpg_state_t       r_state;
    logic [n-1:0]     r_poly;
    logic [n-1:0]     r_pattern;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_num;
    logic [DW-1:0]    r_drain;

    logic [n-1:0]     w_seed_eff;
    logic [n-1:0]     w_next;
    logic             w_pat_valid;
    logic             w_last;

`ifdef TPG_SEED_GUARD_EN
    logic r_seed_err;
    // An all-zero Galois LFSR never leaves zero, so substitute 1.
    assign w_seed_eff = (seed == '0) ? n'(1) : seed;
    assign seed_err   = r_seed_err;
`else
    assign w_seed_eff = seed;
`endif

    assign w_next      = n'(lfsr_next(LFSR_MAX_W'(r_pattern), LFSR_MAX_W'(r_poly), n));
    assign w_pat_valid = (r_state == RUN) && !hold;
    assign w_last      = (r_cnt == r_num - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_poly    <= '0;
            r_pattern <= '0;
            r_cnt     <= '0;
            r_num     <= '0;
            r_drain   <= '0;
`ifdef TPG_SEED_GUARD_EN
            r_seed_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_poly <= poly;
                        r_num  <= num_pat;
                        r_cnt  <= '0;
`ifdef TPG_SEED_GUARD_EN
                        r_seed_err <= (seed == '0);
`endif
                        if (num_pat != '0) begin
                            r_pattern <= w_seed_eff;
                            r_state   <= RUN;
                        end else begin
                            r_state   <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (w_pat_valid) begin
                        r_pattern <= w_next;
                        r_cnt     <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_state <= DRAIN;
                            r_drain <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // Gives the CUT pipeline LAT cycles to flush into the MISR.
                    if (r_drain == DW'(LAT - 1)) r_state <= DONE;
                    else                         r_drain <= r_drain + DW'(1);
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    bist_delay_line #(.LAT(LAT)) u_misr_dly (
        .clk (clk),
        .rst (rst),
        .i_d (w_pat_valid),
        .o_q (misr_en)
    );

    assign pattern   = r_pattern;
    assign pat_valid = w_pat_valid;
    assign busy      = (r_state == RUN) || (r_state == DRAIN);
    assign done      = (r_state == DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bist_tpg.sv
// Directed bench for bist_tpg: the driver pushes expected patterns and
// misr_en/done cycles; a negedge monitor pops and compares them.
module tb_bist_tpg;
    import bist_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic [7:0]  poly = '0;
    logic [7:0]  seed = '0;
    logic [15:0] num_pat = '0;
    logic [7:0]  pattern;
    logic        pat_valid;
    logic        misr_en;
    logic        busy;
    logic        done;
    tpg_state_t  dbg_state;
`ifdef TPG_SEED_GUARD_EN
    logic        seed_err;
`endif

    bist_tpg #(.n(8), .CNT_W(16), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .hold      (hold),
        .poly      (poly),
        .seed      (seed),
        .num_pat   (num_pat),
        .pattern   (pattern),
        .pat_valid (pat_valid),
        .misr_en   (misr_en),
        .busy      (busy),
        .done      (done),
`ifdef TPG_SEED_GUARD_EN
        .seed_err  (seed_err),
`endif
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int         exp_me_q[$];
    int         exp_done_q[$];
    logic       exp_busy = 1'b0;
    logic       exp_pv = 1'b0;
    logic       chk_en = 1'b0;
    logic       chk_zero = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    // Monitor: samples mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pat_valid", pat_valid, exp_pv);
            if (exp_pv && exp_q.size() != 0) check("pattern", pattern, exp_q.pop_front());
            if (exp_me_q.size() != 0 && exp_me_q[0] == cyc) begin
                check("misr_en", misr_en, 1);
                void'(exp_me_q.pop_front());
            end else begin
                check("misr_en idle", misr_en, 0);
            end
            if (exp_done_q.size() != 0 && exp_done_q[0] == cyc) begin
                check("done", done, 1);
                void'(exp_done_q.pop_front());
            end else begin
                check("done idle", done, 0);
            end
            check("busy", busy, exp_busy);
            if (chk_zero)
                check("reset outputs", {pattern, pat_valid, misr_en, busy, done, dbg_state}, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pats(input logic [7:0] a, b, c, d, e, f, input int cnt);
        logic [7:0] t[6];
        t = '{a, b, c, d, e, f};
        for (int i = 0; i < cnt; i++) exp_q.push_back(t[i]);
    endtask

    // One run: hold is high for hl cycles starting hs cycles after the first
    // pattern; glitch re-pulses start and scrambles the inputs mid-run.
    task automatic run(input logic [7:0] sd, pl, input logic [15:0] np,
                       input int hs, hl, input bit glitch);
        int k, s, cnt, j;
        bit h;
        seed = sd; poly = pl; num_pat = np; start = 1'b1;
        k = cyc + 1;
        tick();
        start = 1'b0;
        if (np == 0) begin
            exp_done_q.push_back(k);
            exp_busy = 1'b0; exp_pv = 1'b0;
            tick(); tick();
            return;
        end
        s = k; cnt = 0; j = k;
        for (int g = 0; g < 64 && cnt < np; g++) begin
            h = (s - k >= hs) && (s - k < hs + hl);
            hold = h; exp_busy = 1'b1; exp_pv = !h;
            if (glitch) begin
                if (s - k == 1) begin
                    start = 1'b1; seed = 8'hFF; poly = 8'h00; num_pat = 16'd2;
                end else begin
                    start = 1'b0;
                end
            end
            if (!h) begin
                exp_me_q.push_back(s + LAT);
                cnt++;
                j = s;
            end
            tick();
            s++;
        end
        for (int d = 0; d < LAT; d++) begin
            hold = 1'b1; start = 1'b1; exp_pv = 1'b0; exp_busy = 1'b1;
            if (d == 0) exp_done_q.push_back(j + LAT + 1);
            tick();
        end
        hold = 1'b0; start = 1'b0; exp_busy = 1'b0; exp_pv = 1'b0;
        tick();
        tick();
    endtask

    task automatic reset_mid_run();
        int k;
        push_pats(8'h01, 8'hB8, 8'h5C, 8'h00, 8'h00, 8'h00, 3);
        seed = 8'h01; poly = 8'hB8; num_pat = 16'd6; start = 1'b1;
        k = cyc + 1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 3; r++) begin
            exp_busy = 1'b1; exp_pv = 1'b1;
            if (r == 0) exp_me_q.push_back(k + LAT);
            if (r == 2) rst = 1'b0;
            tick();
        end
        rst = 1'b1; exp_busy = 1'b0; exp_pv = 1'b0; chk_zero = 1'b1;
        tick();
        tick();
        chk_zero = 1'b0;
    endtask

    initial begin
        tick(); tick();
        chk_en = 1'b1; chk_zero = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk_zero = 1'b0;

        push_pats(8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 6);
        run(8'h01, 8'hB8, 16'd6, 0, 0, 1'b0);

        push_pats(8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 6);
        run(8'h01, 8'hB8, 16'd6, 2, 2, 1'b0);

        run(8'h01, 8'hB8, 16'd0, 0, 0, 1'b0);

        reset_mid_run();
        push_pats(8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 6);
        run(8'h01, 8'hB8, 16'd6, 0, 0, 1'b0);

        push_pats(8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 6);
        run(8'h01, 8'hB8, 16'd6, 0, 0, 1'b1);

        push_pats(8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h00, 5);
        run(8'h80, 8'hB8, 16'd5, 1, 3, 1'b0);

        push_pats(8'hFF, 8'hF1, 8'hF6, 8'h00, 8'h00, 8'h00, 3);
        run(8'hFF, 8'h8E, 16'd3, 0, 0, 1'b0);

        push_pats(8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1);
        run(8'h5A, 8'hB8, 16'd1, 0, 0, 1'b0);

`ifdef TPG_SEED_GUARD_EN
        push_pats(8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 6);
        run(8'h00, 8'hB8, 16'd6, 0, 0, 1'b0);
        check("seed_err set", seed_err, 1);
        push_pats(8'h01, 8'hB8, 8'h5C, 8'h00, 8'h00, 8'h00, 3);
        run(8'h01, 8'hB8, 16'd3, 0, 0, 1'b0);
        check("seed_err clear", seed_err, 0);
`else
        push_pats(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 6);
        run(8'h00, 8'hB8, 16'd6, 0, 0, 1'b0);
`endif

        tick();
        check("pattern queue drained", exp_q.size(), 0);
        check("misr_en queue drained", exp_me_q.size(), 0);
        check("done queue drained", exp_done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
